// File: rtl/tl_mem_responder.sv
// TileLink-UL responder: single-beat Get/PutFull/PutPartial serviced from an
// internal word memory, one transaction outstanding, fixed A-to-D latency.
//
// state | meaning
// IDLE  | a_ready high, waiting for a request on channel A
// WAIT  | request captured, counting down the response latency
// RESP  | d_valid high, response held until d_ready
module tl_mem_responder #(
    parameter int                 ADDR_W     = 32,
    parameter int                 DATA_W     = 32,
    parameter int                 SOURCE_W   = 2,
    parameter int                 DEPTH_LOG2 = 10,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = 32'h0001_0000,
    parameter int                 LATENCY    = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_bits_opcode,
    input  logic [2:0]          a_bits_param,
    input  logic [3:0]          a_bits_size,
    input  logic [SOURCE_W-1:0] a_bits_source,
    input  logic [ADDR_W-1:0]   a_bits_address,
    input  logic [3:0]          a_bits_mask,
    input  logic [DATA_W-1:0]   a_bits_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_bits_opcode,
    output logic [1:0]          d_bits_param,
    output logic [3:0]          d_bits_size,
    output logic [SOURCE_W-1:0] d_bits_source,
    output logic [1:0]          d_bits_sink,
    output logic [1:0]          d_bits_addr_lo,
    output logic [DATA_W-1:0]   d_bits_data,
    output logic                d_bits_error
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(4 * DEPTH);
    localparam logic [3:0]        CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [2:0]        OP_ACK      = 3'd0;
    localparam logic [2:0]        OP_ACK_DATA = 3'd1;
    localparam logic [2:0]        OP_HINT_ACK = 3'd2;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  a_ready_q, a_ready_d;
    logic [2:0]            op_q, op_d;
    logic [3:0]            size_q, size_d;
    logic [SOURCE_W-1:0]   source_q, source_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  error_q, error_d;

    logic [ADDR_W-1:0]     offset;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  in_range, aligned, legal, accept, mem_we;
    logic                  unused_ok;

    assign unused_ok = ^a_bits_param;

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign offset   = a_bits_address - BASE_ADDR;
    assign in_range = offset < MEM_BYTES;
    assign word_idx = offset[DEPTH_LOG2+1:2];

    always_comb begin
        aligned = 1'b0;
        case (a_bits_size)
            4'd0:    aligned = 1'b1;
            4'd1:    aligned = ~a_bits_address[0];
            4'd2:    aligned = (a_bits_address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign legal  = in_range && aligned;
    assign accept = a_valid && a_ready_q;
    assign mem_we = accept && legal && (a_bits_opcode == 3'd0 || a_bits_opcode == 3'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        size_d    = size_q;
        source_d  = source_q;
        addr_lo_d = addr_lo_q;
        data_d    = data_q;
        error_d   = error_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = (LATENCY == 1) ? RESP : WAIT;
                    cnt_d     = CNT_INIT;
                    size_d    = a_bits_size;
                    source_d  = a_bits_source;
                    addr_lo_d = a_bits_address[1:0];
                    data_d    = '0;
                    case (a_bits_opcode)
                        3'd0, 3'd1: begin
                            op_d    = OP_ACK;
                            error_d = ~legal;
                        end
                        3'd4: begin
                            op_d    = OP_ACK_DATA;
                            error_d = ~legal;
                            data_d  = legal ? mem_q[word_idx] : '0;
                        end
                        3'd5: begin
                            op_d    = OP_HINT_ACK;
                            error_d = 1'b0;
                        end
                        3'd2, 3'd3: begin
                            op_d    = OP_ACK_DATA;
                            error_d = 1'b1;
                        end
                        default: begin
                            op_d    = OP_ACK;
                            error_d = 1'b1;
                        end
                    endcase
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (d_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        a_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_ready_q <= 1'b0;
            op_q      <= '0;
            size_q    <= '0;
            source_q  <= '0;
            addr_lo_q <= '0;
            data_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_ready_q <= a_ready_d;
            op_q      <= op_d;
            size_q    <= size_d;
            source_q  <= source_d;
            addr_lo_q <= addr_lo_d;
            data_q    <= data_d;
            error_q   <= error_d;
        end
    end

    // Memory is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (a_bits_mask[i]) mem_q[word_idx][8*i +: 8] <= a_bits_data[8*i +: 8];
            end
        end
    end

    assign a_ready        = a_ready_q;
    assign d_valid        = (state_q == RESP);
    assign d_bits_opcode  = op_q;
    assign d_bits_param   = 2'b00;
    assign d_bits_size    = size_q;
    assign d_bits_source  = source_q;
    assign d_bits_sink    = 2'b00;
    assign d_bits_addr_lo = addr_lo_q;
    assign d_bits_data    = data_q;
    assign d_bits_error   = error_q;

endmodule

// File: tb/tb_tl_mem_responder.sv
// Directed bench for tl_mem_responder: expected D responses are queued when a
// request is driven and compared when the response appears.
module tb_tl_mem_responder;

    localparam int LAT = 3;

    logic        clock, reset;
    logic        a_valid, a_ready;
    logic [2:0]  a_bits_opcode, a_bits_param;
    logic [3:0]  a_bits_size;
    logic [1:0]  a_bits_source;
    logic [31:0] a_bits_address;
    logic [3:0]  a_bits_mask;
    logic [31:0] a_bits_data;
    logic        d_valid, d_ready;
    logic [2:0]  d_bits_opcode;
    logic [1:0]  d_bits_param;
    logic [3:0]  d_bits_size;
    logic [1:0]  d_bits_source;
    logic [1:0]  d_bits_sink;
    logic [1:0]  d_bits_addr_lo;
    logic [31:0] d_bits_data;
    logic        d_bits_error;

    tl_mem_responder #(.LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param),
        .a_bits_size(a_bits_size), .a_bits_source(a_bits_source),
        .a_bits_address(a_bits_address), .a_bits_mask(a_bits_mask),
        .a_bits_data(a_bits_data),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
        .d_bits_size(d_bits_size), .d_bits_source(d_bits_source),
        .d_bits_sink(d_bits_sink), .d_bits_addr_lo(d_bits_addr_lo),
        .d_bits_data(d_bits_data), .d_bits_error(d_bits_error)
    );

    typedef struct {
        logic [2:0]  op;
        logic        err;
        logic [31:0] data;
        logic [1:0]  src;
        logic [3:0]  size;
        logic [1:0]  lo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic [1:0] src);
        a_valid        = 1'b1;
        a_bits_opcode  = op;
        a_bits_address = addr;
        a_bits_size    = size;
        a_bits_mask    = mask;
        a_bits_data    = data;
        a_bits_source  = src;
    endtask

    // Drives one request, waits for acceptance and queues the expected response.
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] size,
                        input logic [3:0] mask, input logic [31:0] data, input logic [1:0] src,
                        input logic [2:0] e_op, input logic e_err, input logic [31:0] e_data);
        exp_t e;
        int   k = 0;
        drive(op, addr, size, mask, data, src);
        while (a_ready !== 1'b1 && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check("a_ready_before_accept", 32'(a_ready), 32'd1);
        @(posedge clock); #1;
        a_valid = 1'b0;
        e.op = e_op; e.err = e_err; e.data = e_data;
        e.src = src; e.size = size; e.lo = addr[1:0];
        sb.push_back(e);
    endtask

    task automatic cmp_d(input string pfx, input exp_t e);
        check({pfx, "_valid"},   32'(d_valid), 32'd1);
        check({pfx, "_opcode"},  32'(d_bits_opcode), 32'(e.op));
        check({pfx, "_error"},   32'(d_bits_error), 32'(e.err));
        check({pfx, "_data"},    d_bits_data, e.data);
        check({pfx, "_source"},  32'(d_bits_source), 32'(e.src));
        check({pfx, "_size"},    32'(d_bits_size), 32'(e.size));
        check({pfx, "_addr_lo"}, 32'(d_bits_addr_lo), 32'(e.lo));
        check({pfx, "_param"},   32'(d_bits_param), 32'd0);
        check({pfx, "_sink"},    32'(d_bits_sink), 32'd0);
    endtask

    // Called right after acceptance; checks latency, contents, stall hold and handshake.
    task automatic recv(input int stall);
        exp_t e;
        int   k = 0;
        while (d_valid !== 1'b1 && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        check("latency", 32'(k), 32'(LAT));
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp_d("d", e);
            for (int s = 0; s < stall; s++) begin
                @(posedge clock); #1;
                cmp_d("stall", e);
                check("stall_a_ready", 32'(a_ready), 32'd0);
            end
        end
        d_ready = 1'b1;
        @(posedge clock); #1;
        d_ready = 1'b0;
        check("post_hs_d_valid", 32'(d_valid), 32'd0);
        check("post_hs_a_ready", 32'(a_ready), 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        d_ready      = 1'b0;
        a_bits_param = 3'd0;
        drive(3'd4, 32'h0000_FFFC, 4'd2, 4'hF, 32'h0, 2'd1);

        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("rst_a_ready", 32'(a_ready), 32'd0);
            check("rst_d_valid", 32'(d_valid), 32'd0);
            check("rst_d_opcode", 32'(d_bits_opcode), 32'd0);
            check("rst_d_data", d_bits_data, 32'd0);
            check("rst_d_misc", {d_bits_size, d_bits_source, d_bits_addr_lo, d_bits_error}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("rel_a_ready", 32'(a_ready), 32'd1);

        // Below-base Get held across reset release: out of range.
        send(3'd4, 32'h0000_FFFC, 4'd2, 4'hF, 32'h0, 2'd1, 3'd1, 1'b1, 32'h0);
        recv(0);

        send(3'd0, 32'h0001_0004, 4'd2, 4'hF, 32'hDEAD_BEEF, 2'd2, 3'd0, 1'b0, 32'h0);
        recv(0);
        send(3'd4, 32'h0001_0004, 4'd2, 4'hF, 32'h0, 2'd3, 3'd1, 1'b0, 32'hDEAD_BEEF);
        recv(0);

        send(3'd1, 32'h0001_0004, 4'd2, 4'h2, 32'h0000_5500, 2'd0, 3'd0, 1'b0, 32'h0);
        recv(0);
        send(3'd4, 32'h0001_0004, 4'd2, 4'h0, 32'h0, 2'd1, 3'd1, 1'b0, 32'hDEAD_55EF);
        recv(5);

        send(3'd4, 32'h0001_1000, 4'd2, 4'hF, 32'h0, 2'd2, 3'd1, 1'b1, 32'h0);
        recv(0);
        send(3'd4, 32'h0001_0006, 4'd2, 4'hF, 32'h0, 2'd3, 3'd1, 1'b1, 32'h0);
        recv(0);
        send(3'd0, 32'h0001_0006, 4'd2, 4'hF, 32'h1111_1111, 2'd0, 3'd0, 1'b1, 32'h0);
        recv(0);
        send(3'd0, 32'h0001_1000, 4'd2, 4'hF, 32'h2222_2222, 2'd0, 3'd0, 1'b1, 32'h0);
        recv(0);
        send(3'd4, 32'h0001_0004, 4'd2, 4'hF, 32'h0, 2'd1, 3'd1, 1'b0, 32'hDEAD_55EF);
        recv(0);

        // Last word in range, then a legal halfword read of its upper half.
        send(3'd0, 32'h0001_0FFC, 4'd2, 4'hF, 32'h1234_5678, 2'd2, 3'd0, 1'b0, 32'h0);
        recv(0);
        send(3'd4, 32'h0001_0FFE, 4'd1, 4'hC, 32'h0, 2'd3, 3'd1, 1'b0, 32'h1234_5678);
        recv(0);

        send(3'd5, 32'h0001_0004, 4'd2, 4'hF, 32'h0, 2'd1, 3'd2, 1'b0, 32'h0);
        recv(0);
        send(3'd2, 32'h0001_0004, 4'd2, 4'hF, 32'h0, 2'd2, 3'd1, 1'b1, 32'h0);
        recv(0);
        send(3'd6, 32'h0001_0004, 4'd2, 4'hF, 32'h0, 2'd3, 3'd0, 1'b1, 32'h0);
        recv(0);
        send(3'd4, 32'h0001_0004, 4'd3, 4'hF, 32'h0, 2'd0, 3'd1, 1'b1, 32'h0);
        recv(0);

        // Reset while the Put waits for its response: response dropped, write kept.
        send(3'd0, 32'h0001_0008, 4'd2, 4'hF, 32'hCAFE_F00D, 2'd2, 3'd0, 1'b0, 32'h0);
        void'(sb.pop_back());
        reset = 1'b1;
        #1;
        check("wait_rst_d_valid", 32'(d_valid), 32'd0);
        check("wait_rst_a_ready", 32'(a_ready), 32'd0);
        check("wait_rst_d_size", 32'(d_bits_size), 32'd0);
        check("wait_rst_d_source", 32'(d_bits_source), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            check("after_rst_no_resp", 32'(d_valid), 32'd0);
        end
        send(3'd4, 32'h0001_0008, 4'd2, 4'hF, 32'h0, 2'd1, 3'd1, 1'b0, 32'hCAFE_F00D);
        recv(0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
